// File: rtl/multilane_phy_rx.sv
// Per-lane comma-aligned deserialiser: SEARCH -> COUNT -> LOCKED, words out one cycle after their last bit.
// No backpressure; enable=0 freezes every lane and suppresses valid_out.
module multilane_phy_rx #(
    parameter int                LANES    = 2,
    parameter int                WORD_W   = 8,
    parameter logic [WORD_W-1:0] COMMA    = 8'hBC,
    parameter logic [WORD_W-1:0] IDLE     = 8'h7C,
    parameter int                LOCK_CNT = 4,
    parameter bit                REALIGN  = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [LANES-1:0]          din,
    output logic [LANES*WORD_W-1:0]   data_out,
    output logic [LANES-1:0]          valid_out,
    output logic [LANES-1:0]          active,
    output logic                      all_active
);

    localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int CW = $clog2(LOCK_CNT + 1) > 0 ? $clog2(LOCK_CNT + 1) : 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        state_t            st;
        logic [BW-1:0]     bcnt;
        logic [CW-1:0]     cnt;
        logic [WORD_W-2:0] sr;
    } lane_t;

    lane_t [LANES-1:0]          lane_q, lane_d;
    logic  [LANES*WORD_W-1:0]   data_q, data_d;
    logic  [LANES-1:0]          valid_q, valid_d;
    logic  [LANES-1:0]          active_q, active_d;
    logic                       all_active_q, all_active_d;

    logic  [LANES-1:0][WORD_W-1:0] w;
    logic  [LANES-1:0]             bnd;

    always_comb begin
        w   = '0;
        bnd = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i]   = {lane_q[i].sr, din[i]};
            bnd[i] = (lane_q[i].bcnt == BW'(WORD_W - 1));
        end
    end

    always_comb begin
        lane_d       = lane_q;
        data_d       = data_q;
        valid_d      = '0;
        active_d     = active_q;
        all_active_d = all_active_q;
        if (enable) begin
            for (int i = 0; i < LANES; i++) begin
                lane_d[i].sr   = w[i][WORD_W-2:0];
                lane_d[i].bcnt = bnd[i] ? '0 : lane_q[i].bcnt + 1'b1;
                case (lane_q[i].st)
                    SEARCH: begin
                        lane_d[i].bcnt = lane_q[i].bcnt;
                        if (w[i] == COMMA) begin
                            lane_d[i].bcnt = '0;
                            lane_d[i].cnt  = CW'(1);
                            lane_d[i].st   = (LOCK_CNT == 1) ? LOCKED : COUNT;
                        end
                    end
                    COUNT: begin
                        if (bnd[i]) begin
                            if (w[i] == COMMA) begin
                                lane_d[i].cnt = lane_q[i].cnt + 1'b1;
                                if (lane_q[i].cnt + 1'b1 >= CW'(LOCK_CNT))
                                    lane_d[i].st = LOCKED;
                            end else begin
                                lane_d[i].cnt = '0;
                                lane_d[i].st  = SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        if (bnd[i]) begin
                            data_d[i*WORD_W +: WORD_W] = w[i];
                            valid_d[i] = (w[i] != COMMA) && (w[i] != IDLE);
                        end else if (REALIGN && (w[i] == COMMA)) begin
                            // Off-boundary comma: restart the count with this comma as the first.
                            lane_d[i].st   = COUNT;
                            lane_d[i].bcnt = '0;
                            lane_d[i].cnt  = CW'(1);
                        end
                    end
                    default: begin
                        lane_d[i].st  = SEARCH;
                        lane_d[i].cnt = '0;
                    end
                endcase
                active_d[i] = (lane_d[i].st == LOCKED);
            end
            all_active_d = &active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            active_q     <= '0;
            all_active_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            active_q     <= active_d;
            all_active_q <= all_active_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign active     = active_q;
    assign all_active = all_active_q;

endmodule
